// File: rtl/cb_enq_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cb_enq_arb
//  Purpose  : Round-robin arbiter sharing one credit-tracked cb enqueue port
//             among NUM_REQ requesters. Grants are issued only when the cb has
//             a free entry, or when an entry frees up in the same cycle. The
//             granted word reaches the cb one cycle later.
//  Options  : CB_ENQ_ARB_STALL_CNT_EN adds a 16-bit saturating stall_cnt output
//             that counts cycles where a request was blocked by full credits.
//  Revision : 1.0  initial release
// ============================================================================
module cb_enq_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int CB_ENTRIES = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cb_enq_valid,
  output logic [DATA_WIDTH-1:0]         cb_enq_data,
  input  logic                          cb_deq_fire,
`ifdef CB_ENQ_ARB_STALL_CNT_EN
  output logic [15:0]                   stall_cnt,
`endif
  output logic [$clog2(CB_ENTRIES+1)-1:0] occupancy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int OCC_W = $clog2(CB_ENTRIES+1);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  enq_valid_q;
  logic [DATA_WIDTH-1:0] enq_data_q, enq_data_d;

  logic                  permit;
  logic                  grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  deq_eff;

  // A grant may go out while a credit is free, or when the cb is full but an
  // entry leaves in this same cycle.
  assign permit  = (occ_q < OCC_W'(CB_ENTRIES)) ||
                   (cb_deq_fire && (occ_q == OCC_W'(CB_ENTRIES)));
  // A dequeue against an empty cb is ignored so the credit count cannot wrap.
  assign deq_eff = cb_deq_fire && (occ_q != '0);

  // Round-robin search upward from rr_ptr with wrap; one-hot grant output.
  always_comb begin
    int idx;
    grant     = 1'b0;
    grant_idx = '0;
    req_ready = '0;
    idx       = 0;
    if (permit && nRST) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant && req_valid[idx]) begin
          grant     = 1'b1;
          grant_idx = PTR_W'(idx);
        end
      end
    end
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  // Next-state for pointer, credit count and enqueue data.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    occ_d      = occ_q;
    enq_data_d = enq_data_q;
    if (grant) begin
      rr_ptr_d   = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      enq_data_d = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
    case ({grant, deq_eff})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset drops any in-flight enqueue.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_q    <= '0;
      occ_q       <= '0;
      enq_valid_q <= 1'b0;
      enq_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      occ_q       <= occ_d;
      enq_valid_q <= grant;
      enq_data_q  <= enq_data_d;
    end
  end

  assign cb_enq_valid = enq_valid_q;
  assign cb_enq_data  = enq_data_q;
  assign occupancy    = occ_q;

`ifdef CB_ENQ_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Count cycles with a pending request blocked only by full credits.
  always_comb begin
    stall_d = stall_q;
    if ((|req_valid) && !permit && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

`ifndef SYNTHESIS
  // Flag a dequeue reported while the cb is known to be empty.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      assert (!(cb_deq_fire && (occ_q == '0)))
        else $error("cb_enq_arb: cb_deq_fire with zero occupancy");
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/cb_enq_arb.md
CB_ENQ_ARB -- requirements
Module: cb_enq_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each enqueued data word.
REQ-002 Parameter NUM_REQ, default 4, number of requesters sharing one cb enqueue port (legal range 2..16).
REQ-003 Parameter CB_ENTRIES, default 4, entry count of the downstream cb (NUM_ENTRIES there).
REQ-004 Port CLK  in  1  clock; all state updates on the rising edge.
REQ-005 Port nRST  in  1  asynchronous active-low reset.
REQ-006 Port req_valid  in  NUM_REQ  per-requester enqueue request.
REQ-007 Port req_data  in  NUM_REQ x DATA_WIDTH  per-requester data; sampled only on that requester's grant.
REQ-008 Port req_ready  out  NUM_REQ  one-hot-or-zero grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-009 Port cb_enq_valid  out  1  drives cb enq_valid.
REQ-010 Port cb_enq_data  out  DATA_WIDTH  drives cb enq_data.
REQ-011 Port cb_deq_fire  in  1  cb deq_valid & deq_ready, one pulse per dequeued entry.
REQ-012 Port occupancy  out  $clog2(CB_ENTRIES+1)  current credit count (entries granted and not yet dequeued).

Function
REQ-013 req_ready is combinational from req_valid, rr_ptr, occupancy, cb_deq_fire; at most one bit is set per cycle.
REQ-014 Grant is permitted when occupancy < CB_ENTRIES, or when occupancy == CB_ENTRIES and cb_deq_fire is 1 the same cycle.
REQ-015 When grant is permitted, the winner is the first requester with req_valid set, searching upward from rr_ptr with wrap from NUM_REQ-1 to 0.
REQ-016 After a grant to requester i, rr_ptr becomes (i+1) mod NUM_REQ; with no grant, rr_ptr holds.
REQ-017 Enqueue latency is one cycle: the cycle after a grant, cb_enq_valid = 1 and cb_enq_data = the granted req_data; otherwise cb_enq_valid = 0 and cb_enq_data holds its last value.
REQ-018 Occupancy next = occupancy + grant - cb_deq_fire; simultaneous grant and deq fire leave occupancy unchanged.
REQ-019 Occupancy never exceeds CB_ENTRIES; no grant is issued that would overflow the cb.
REQ-020 cb_deq_fire with occupancy == 0 is illegal; occupancy holds at 0 and a simulation-only assertion fires.
REQ-021 With no req_valid set, no grant occurs, rr_ptr holds, and occupancy changes only by cb_deq_fire.
REQ-022 Sustained throughput is one enqueue per cycle while credits are available.

Reset
REQ-023 On nRST low, asynchronously: req_ready = 0, cb_enq_valid = 0, cb_enq_data = 0, occupancy = 0, rr_ptr = 0.
REQ-024 Reset mid-operation discards any in-flight enqueue; the downstream cb is reset by the same nRST, so credits and cb contents stay consistent.
REQ-025 The first grant is possible in the first rising edge after nRST deasserts.

Configuration
REQ-026 Macro CB_ENQ_ARB_STALL_CNT_EN, when defined, adds output stall_cnt (16 bits) counting cycles with any req_valid set and no grant due to full credits, saturating at 16'hFFFF and reset to 0.
REQ-027 Without CB_ENQ_ARB_STALL_CNT_EN, port stall_cnt and its counter do not exist; all other behaviour is identical.

Verification (NUM_REQ=4, CB_ENTRIES=4, DATA_WIDTH=32)
REQ-028 Single requester: req_valid=4'b0010, data 0xA5 -> req_ready=4'b0010 same cycle; next cycle cb_enq_valid=1, cb_enq_data=0xA5; occupancy=1.
REQ-029 Round robin: req_valid=4'b1111 held, no deq -> grants in order 0,1,2,3, then req_ready=0 with occupancy=4.
REQ-030 Full plus deq: occupancy=4, req_valid=4'b0001, cb_deq_fire=1 -> req_ready=4'b0001, occupancy stays 4.
REQ-031 Wrap priority: rr_ptr=3, req_valid=4'b1001 -> grant 3, then grant 0; rr_ptr ends at 1.
REQ-032 Reset mid-stream: assert nRST with occupancy=3 and cb_enq_valid=1 -> all outputs 0 immediately, first post-reset grant to lowest valid index.
REQ-033 With CB_ENQ_ARB_STALL_CNT_EN: occupancy=4, req_valid=4'b0100, no deq for 10 cycles -> stall_cnt=10.
